mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Controller that shares one single-ported unified memory between the pipelined CPU's instruction fetch (IF) and data access (MEM) stages. Each pipeline step, it serializes the pending data access and then the pending fetch onto the memory bus with a req/ack handshake. It holds the results in registers and asserts a pipeline-wide `stall` until both accesses are complete. It sits between the CPU core (`pc`/`instr`, `memaddr`/`memwritedata`/`memreaddata`/`memwrite`) and the external memory model.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: wait cycles before abort. Used only with `ARB_TIMEOUT_EN`. Counter width is 8 bits, so the valid range is 1..255.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch wanted this step.
- `if_addr`  in  AW  fetch address (PC).
- `if_instr`  out  DW  fetched word, registered.
- `d_req`  in  1  data access wanted this step.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data, registered.
- `stall`  out  1  freeze all pipeline registers and the PC.
- `m_req`  out  1  memory request, registered.
- `m_we`  out  1  memory write enable, registered.
- `m_addr`  out  AW  memory address, registered.
- `m_wdata`  out  DW  memory write data, registered.
- `m_rdata`  in  DW  memory read data.
- `m_ack`  in  1  memory completion, sampled at the clock edge.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, DATA, FETCH, DONE.
- **IDLE**
  - If `d_req`=1: latch `d_addr`/`d_wdata`/`d_we` into `m_*` and go to DATA.
  - Else if `if_req`=1: latch `if_addr`, set `m_we`=0, and go to FETCH.
  - Else go to DONE.
  - `m_ack` is ignored in IDLE.
- **DATA**
  - `m_req`=1.
  - On an edge with `m_ack`=1: capture `m_rdata` into `d_rdata` (loads only; a store leaves `d_rdata` unchanged).
  - Then: if `if_req`=1, latch `if_addr`, set `m_we`=0 and go to FETCH; else go to DONE.
- **FETCH**
  - `m_req`=1, `m_we`=0.
  - On an edge with `m_ack`=1: capture `m_rdata` into `if_instr` and go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle; the pipeline advances at the closing edge.
  - Next state is IDLE.
- `stall` = 1 in every state except DONE. It is decoded from registered state, so it is glitch-free.
- Data access always precedes fetch, because the MEM-stage instruction is older.
- `m_addr`/`m_wdata`/`m_we` are stable for the whole time `m_req`=1. Requester inputs may change while `stall`=1 without effect on an in-flight access.
- `m_req` drops in the cycle after the ack edge.

## Timing
- Reset values: state=IDLE, `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `if_instr`=0, `d_rdata`=0, `bus_error`=0. `stall`=1 while in IDLE.
- Latency with a zero-wait memory (`m_ack`=1 in the first request cycle):
  - Fetch only: IDLE, FETCH, DONE → 3 cycles per step, `stall` low in cycle 3.
  - Data + fetch: 4 cycles.
  - Neither request: 2 cycles (IDLE, DONE).
- Each wait cycle (`m_ack`=0) adds one cycle to the step.
- `if_instr`/`d_rdata` are valid from the cycle after capture until the next capture, so they are valid throughout DONE.
- Reset asserted mid-access:
  - Go immediately to IDLE with `m_req`=0.
  - Discard the partial access.
  - A late `m_ack` after reset release is ignored (IDLE).
- `m_ack` outside DATA/FETCH is ignored.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to DATA/FETCH and increments on each edge with `m_ack`=0.
  - When the counter reaches `TIMEOUT` with `m_ack` still 0, the access completes as if acked, with captured data = 0.
  - `bus_error` is set to 1 and stays high until reset.
  - The FSM continues normally.
- **Undefined:**
  - No counter; the arbiter waits indefinitely for `m_ack`.
  - `bus_error` is tied to 0.

## Test plan
- **Reset and fetch-only.** Hold `reset`=0 then release; `if_req`=1, `if_addr`=0x00, memory acks immediately with 0x20080005.
  - `stall` pattern 1,1,0 repeating.
  - `m_addr`=0x00 during FETCH.
  - `if_instr`=0x20080005 in DONE.
- **Load + fetch.** `d_req`=1, `d_we`=0, `d_addr`=0x40, memory[0x40]=0xDEADBEEF; `if_addr`=0x04.
  - DATA issues 0x40, then FETCH issues 0x04.
  - `d_rdata`=0xDEADBEEF.
  - `stall` low only in cycle 4.
- **Store with 2 wait states.** `d_we`=1, `d_wdata`=0x12345678, `d_addr`=0x80.
  - `m_we`=1 with stable address/data for 3 cycles.
  - Memory[0x80]=0x12345678.
  - `d_rdata` unchanged.
- **Requester changes inputs while stalled.** Change `d_addr` to 0xFF during DATA.
  - `m_addr` stays 0x40 until ack.
- **Reset mid-FETCH.** Assert reset in the second wait cycle.
  - `m_req`=0 asynchronously.
  - A stale `m_ack` pulse after release does not update `if_instr`.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT`=4).** Memory never acks.
  - `m_req` high for 5 cycles.
  - `if_instr`=0.
  - `bus_error`=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, data first.
// Optional bus timeout with sticky bus_error: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_instr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          bus_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic          in_access;
  logic          timed_out;
  logic          acc_done;
  logic [DW-1:0] acc_data;

  assign in_access = (state == DATA) || (state == FETCH);
  assign acc_done  = in_access && (m_ack || timed_out);
  // An aborted access delivers zero instead of whatever sits on m_rdata.
  assign acc_data  = m_ack ? m_rdata : '0;
  assign stall     = (state != DONE);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timed_out = in_access && !m_ack && (wait_cnt == TIMEOUT[7:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      // Cleared outside an access and on completion, so every DATA/FETCH entry starts at 0.
      if (!in_access || acc_done) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + 8'd1;
      if (timed_out) bus_error <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign bus_error      = 1'b0;
  assign unused_timeout = ^TIMEOUT[7:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_instr <= '0;
      d_rdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (d_req) begin
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_we    <= d_we;
            m_req   <= 1'b1;
            state   <= DATA;
          end else if (if_req) begin
            m_addr <= if_addr;
            m_we   <= 1'b0;
            m_req  <= 1'b1;
            state  <= FETCH;
          end else begin
            state <= DONE;
          end
        end
        DATA: begin
          if (acc_done) begin
            if (!m_we) d_rdata <= acc_data;
            if (if_req) begin
              m_addr <= if_addr;
              m_we   <= 1'b0;
              state  <= FETCH;
            end else begin
              m_req <= 1'b0;
              m_we  <= 1'b0;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          if (acc_done) begin
            if_instr <= acc_data;
            m_req    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized steps
// against a step-level reference model and a behavioural word memory.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_instr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_error;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_instr  (if_instr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .stall     (stall),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_instr;
  logic [31:0] exp_rdata;
  logic        exp_berr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One memory access as seen on the bus: wait cycles then an ack, or never ack (wait < 0).
  task automatic phase(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                       input int wait_n, input bit is_data);
    int  n;
    bit  ack;
    n = (wait_n < 0) ? TO + 1 : wait_n + 1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check(is_data ? "data_stall" : "fetch_stall", stall, 1);
      check(is_data ? "data_mreq" : "fetch_mreq", m_req, 1);
      check(is_data ? "data_addr" : "fetch_addr", m_addr, addr);
      check(is_data ? "data_we" : "fetch_we", m_we, we);
      if (we) check("store_wdata", m_wdata, wdata);
      d_req   = 1'($urandom);
      d_we    = 1'($urandom);
      d_addr  = 32'h0000_00FF;
      d_wdata = $urandom;
      if (!is_data) begin
        if_req  = 1'($urandom);
        if_addr = $urandom;
      end
      ack     = (wait_n >= 0) && (c == n - 1);
      m_ack   = ack;
      m_rdata = ack ? mem[addr[9:2]] : $urandom;
      if (ack) begin
        if (we)           mem[m_addr[9:2]] = m_wdata;
        else if (is_data) exp_rdata = mem[addr[9:2]];
        else              exp_instr = mem[addr[9:2]];
      end else if (wait_n < 0 && c == n - 1) begin
        if (is_data && !we) exp_rdata = '0;
        else if (!is_data)  exp_instr = '0;
        exp_berr = 1'b1;
      end
    end
  endtask

  // One pipeline step: IDLE, optional data access, optional fetch, DONE.
  task automatic step(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                      input logic [31:0] daddr, input logic [31:0] dwdata,
                      input int dwait, input int fwait, input bit idle_ack);
    @(negedge clk);
    check("idle_stall", stall, 1);
    check("idle_mreq", m_req, 0);
    if_req  = ireq;
    if_addr = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = dwdata;
    m_ack   = idle_ack;
    m_rdata = $urandom;
    if (dreq) phase(daddr, dwe, dwdata, dwait, 1'b1);
    if (ireq) phase(iaddr, 1'b0, 32'h0, fwait, 1'b0);
    @(negedge clk);
    check("done_stall", stall, 0);
    check("done_mreq", m_req, 0);
    check("done_instr", if_instr, exp_instr);
    check("done_rdata", d_rdata, exp_rdata);
    check("done_berr", bus_error, exp_berr);
    m_ack   = 1'($urandom);
    m_rdata = $urandom;
    d_req   = 1'($urandom);
    if_req  = 1'($urandom);
  endtask

  // Holds reset for two edges and releases just after a posedge, leaving the DUT in IDLE.
  task automatic apply_reset();
    reset     = 1'b0;
    exp_instr = '0;
    exp_rdata = '0;
    exp_berr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_ack   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h00] = 32'h2008_0005;
    mem[8'h10] = 32'hDEAD_BEEF;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mreq", m_req, 0);
    check("rst_mwe", m_we, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_mwdata", m_wdata, 0);
    check("rst_instr", if_instr, 0);
    check("rst_rdata", d_rdata, 0);
    check("rst_berr", bus_error, 0);
    check("rst_stall", stall, 1);
    apply_reset();

    // Fetch-only from 0x00, zero wait: stall 1,1,0 repeating
    repeat (3) step(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);

    // Load 0x40 then fetch 0x04, zero wait: 4-cycle step
    step(1'b1, 32'h04, 1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0);
    check("load_value", d_rdata, 32'hDEAD_BEEF);

    // Store 0x80 with 2 wait states, then fetch 0x08
    step(1'b1, 32'h08, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 2, 0, 1'b0);
    check("store_mem", mem[8'h20], 32'h1234_5678);
    check("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);

    // Load 0x40 with waits while the requester moves d_addr to 0xFF
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2, 0, 1'b1);

    // Neither request: 2-cycle step
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);

    // Reset in the second wait cycle of a fetch, then a stale ack after release
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b0;
    m_ack   = 1'b0;
    @(negedge clk);
    check("rfetch_w1_mreq", m_req, 1);
    @(negedge clk);
    check("rfetch_w2_mreq", m_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rfetch_async_mreq", m_req, 0);
    check("rfetch_async_stall", stall, 1);
    check("rfetch_async_instr", if_instr, 0);
    m_ack   = 1'b1;
    m_rdata = 32'hBAD0_BAD0;
    if_req  = 1'b0;
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Memory never acks a fetch: abort after TIMEOUT+1 request cycles
    step(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, 0, -1, 1'b0);
    step(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0, 1'b0);
    check("timeout_sticky", bus_error, 1);
    @(negedge clk);
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
`endif

    // Randomized steps over a 256-word window
    for (int s = 0; s < 40; s++) begin
      step(1'($urandom), 32'($urandom_range(0, 255)) << 2,
           1'($urandom), 1'($urandom), 32'($urandom_range(0, 255)) << 2, $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
